// File: rtl/tl_ad_channel_buffer_if.sv
// TileLink-UH A/D channel bundle for one link; master drives A and D-ready, slave drives D and A-ready.
interface tl_ad_channel_buffer_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_bits_opcode;
  logic [2:0]  a_bits_param;
  logic [2:0]  a_bits_size;
  logic [3:0]  a_bits_source;
  logic [31:0] a_bits_address;
  logic [7:0]  a_bits_mask;
  logic [63:0] a_bits_data;
  logic        a_bits_corrupt;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_bits_opcode;
  logic [1:0]  d_bits_param;
  logic [2:0]  d_bits_size;
  logic [3:0]  d_bits_source;
  logic [1:0]  d_bits_sink;
  logic        d_bits_denied;
  logic [63:0] d_bits_data;
  logic        d_bits_corrupt;

  modport master (
    output a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    input  a_ready,
    input  d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
    output d_ready
  );

  modport slave (
    input  a_valid, a_bits_opcode, a_bits_param, a_bits_size, a_bits_source,
           a_bits_address, a_bits_mask, a_bits_data, a_bits_corrupt,
    output a_ready,
    output d_valid, d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
           d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt,
    input  d_ready
  );
endinterface

// File: rtl/tl_ad_channel_buffer.sv
// Registered TileLink A/D channel buffer: independent DEPTH-entry FIFO per channel.
// Optional macro TL_AD_BUFFER_FLOW_EN enables flow-through of a beat when the FIFO is empty.

module tl_ad_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_bits_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_bits_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("tl_ad_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, pass, push, pop;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_C);
  // Ready looks only at occupancy, never at out_ready, so no comb path crosses the buffer.
  assign in_ready_o = ~full;

`ifdef TL_AD_BUFFER_FLOW_EN
  assign pass        = empty & in_valid_i & out_ready_i;
  assign out_valid_o = ~empty | in_valid_i;
  assign out_bits_o  = empty ? in_bits_i : mem_q[rptr_q];
`else
  assign pass        = 1'b0;
  assign out_valid_o = ~empty;
  assign out_bits_o  = mem_q[rptr_q];
`endif

  // A bypassed beat is consumed in the same cycle and never touches storage or pointers.
  assign push = in_valid_i & in_ready_o & ~pass;
  assign pop  = out_valid_o & out_ready_i & ~pass;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy alone decides what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= in_bits_i;
  end
endmodule

module tl_ad_channel_buffer #(
  parameter int DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  tl_ad_channel_buffer_if.slave  auto_in,
  tl_ad_channel_buffer_if.master auto_out
);
  localparam int AWIDTH = 118;
  localparam int DWIDTH = 80;

  logic [AWIDTH-1:0] a_in_bits, a_out_bits;
  logic [DWIDTH-1:0] d_in_bits, d_out_bits;

  // A channel: width widget -> crossbar.
  assign a_in_bits = {auto_in.a_bits_opcode, auto_in.a_bits_param, auto_in.a_bits_size,
                      auto_in.a_bits_source, auto_in.a_bits_address, auto_in.a_bits_mask,
                      auto_in.a_bits_data, auto_in.a_bits_corrupt};

  tl_ad_fifo #(.DEPTH(DEPTH), .WIDTH(AWIDTH)) u_a_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (auto_in.a_valid),
    .in_ready_o  (auto_in.a_ready),
    .in_bits_i   (a_in_bits),
    .out_valid_o (auto_out.a_valid),
    .out_ready_i (auto_out.a_ready),
    .out_bits_o  (a_out_bits)
  );

  assign {auto_out.a_bits_opcode, auto_out.a_bits_param, auto_out.a_bits_size,
          auto_out.a_bits_source, auto_out.a_bits_address, auto_out.a_bits_mask,
          auto_out.a_bits_data, auto_out.a_bits_corrupt} = a_out_bits;

  // D channel: crossbar -> width widget.
  assign d_in_bits = {auto_out.d_bits_opcode, auto_out.d_bits_param, auto_out.d_bits_size,
                      auto_out.d_bits_source, auto_out.d_bits_sink, auto_out.d_bits_denied,
                      auto_out.d_bits_data, auto_out.d_bits_corrupt};

  tl_ad_fifo #(.DEPTH(DEPTH), .WIDTH(DWIDTH)) u_d_fifo (
    .clock       (clock),
    .reset       (reset),
    .in_valid_i  (auto_out.d_valid),
    .in_ready_o  (auto_out.d_ready),
    .in_bits_i   (d_in_bits),
    .out_valid_o (auto_in.d_valid),
    .out_ready_i (auto_in.d_ready),
    .out_bits_o  (d_out_bits)
  );

  assign {auto_in.d_bits_opcode, auto_in.d_bits_param, auto_in.d_bits_size,
          auto_in.d_bits_source, auto_in.d_bits_sink, auto_in.d_bits_denied,
          auto_in.d_bits_data, auto_in.d_bits_corrupt} = d_out_bits;
endmodule

// File: tb/tb_tl_ad_channel_buffer.sv
// Directed bench for tl_ad_channel_buffer (DEPTH=2); inputs change and outputs are sampled on the falling edge.
module tb_tl_ad_channel_buffer;
  logic clock = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  tl_ad_channel_buffer_if in_if ();
  tl_ad_channel_buffer_if out_if ();

  tl_ad_channel_buffer #(.DEPTH(2)) dut (
    .clock    (clock),
    .reset    (reset),
    .auto_in  (in_if),
    .auto_out (out_if)
  );

  wire [117:0] out_a = {out_if.a_bits_opcode, out_if.a_bits_param, out_if.a_bits_size,
                        out_if.a_bits_source, out_if.a_bits_address, out_if.a_bits_mask,
                        out_if.a_bits_data, out_if.a_bits_corrupt};
  wire [79:0]  out_d = {in_if.d_bits_opcode, in_if.d_bits_param, in_if.d_bits_size,
                        in_if.d_bits_source, in_if.d_bits_sink, in_if.d_bits_denied,
                        in_if.d_bits_data, in_if.d_bits_corrupt};

  function automatic logic [117:0] a_beat(input logic [2:0] op, input logic [2:0] sz,
                                          input logic [3:0] src, input logic [31:0] addr,
                                          input logic [7:0] mask, input logic [63:0] data);
    return {op, 3'd0, sz, src, addr, mask, data, 1'b0};
  endfunction

  function automatic logic [79:0] d_beat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {3'd1, 2'd0, 3'd3, b[3:0], b[1:0], 1'b0, 64'(i), b[0]};
  endfunction

  task automatic drive_a(input logic v, input logic [117:0] beat);
    in_if.a_valid = v;
    {in_if.a_bits_opcode, in_if.a_bits_param, in_if.a_bits_size, in_if.a_bits_source,
     in_if.a_bits_address, in_if.a_bits_mask, in_if.a_bits_data, in_if.a_bits_corrupt} = beat;
  endtask

  task automatic drive_d(input logic v, input logic [79:0] beat);
    out_if.d_valid = v;
    {out_if.d_bits_opcode, out_if.d_bits_param, out_if.d_bits_size, out_if.d_bits_source,
     out_if.d_bits_sink, out_if.d_bits_denied, out_if.d_bits_data, out_if.d_bits_corrupt} = beat;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    drive_a(1'b0, '0);
    drive_d(1'b0, '0);
    out_if.a_ready = 1'b0;
    in_if.d_ready  = 1'b0;
    repeat (3) begin
      @(negedge clock);
      n_vec++;
      if (out_if.a_valid !== 1'b0 || in_if.d_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_valids: a_valid=%b d_valid=%b expected 0 0", out_if.a_valid, in_if.d_valid);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    n_vec++;
    if (in_if.a_ready !== 1'b1 || out_if.d_ready !== 1'b1 ||
        out_if.a_valid !== 1'b0 || in_if.d_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: a_ready=%b d_ready=%b a_valid=%b d_valid=%b expected 1 1 0 0",
               in_if.a_ready, out_if.d_ready, out_if.a_valid, in_if.d_valid);
    end
  endtask

  task automatic test_single_get;
    logic [117:0] exp;
    exp = a_beat(3'd4, 3'd3, 4'd4, 32'h8000_0040, 8'hFF, 64'd0);
    @(negedge clock);
    out_if.a_ready = 1'b1;
    drive_a(1'b1, exp);
    #1;
`ifdef TL_AD_BUFFER_FLOW_EN
    n_vec++;
    if (out_if.a_valid !== 1'b1 || out_a !== exp) begin
      n_err++;
      $display("FAIL get_flow: valid=%b bits=%h expected 1 %h", out_if.a_valid, out_a, exp);
    end
    @(negedge clock);
    drive_a(1'b0, '0);
`else
    n_vec++;
    if (out_if.a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL get_latency0: valid=%b expected 0", out_if.a_valid);
    end
    @(negedge clock);
    drive_a(1'b0, '0);
    n_vec++;
    if (out_if.a_valid !== 1'b1 || out_a !== exp) begin
      n_err++;
      $display("FAIL get_latency1: valid=%b bits=%h expected 1 %h", out_if.a_valid, out_a, exp);
    end
    @(negedge clock);
`endif
    n_vec++;
    if (out_if.a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL get_drained: valid=%b expected 0", out_if.a_valid);
    end
  endtask

  task automatic test_backpressure;
    logic [117:0] p [3];
    for (int i = 0; i < 3; i++) p[i] = a_beat(3'd0, 3'd3, 4'd1, 32'h1000, 8'hFF, 64'(i + 1));
    @(negedge clock);
    out_if.a_ready = 1'b0;
    drive_a(1'b1, p[0]);
    @(negedge clock);
    drive_a(1'b1, p[1]);
    #1;
    n_vec++;
    if (in_if.a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL put2_ready: a_ready=%b expected 1", in_if.a_ready);
    end
    @(negedge clock);
    drive_a(1'b1, p[2]);
    repeat (3) begin
      #1;
      n_vec++;
      if (in_if.a_ready !== 1'b0 || out_if.a_valid !== 1'b1 || out_a !== p[0]) begin
        n_err++;
        $display("FAIL put_stall: a_ready=%b valid=%b bits=%h expected 0 1 %h",
                 in_if.a_ready, out_if.a_valid, out_a, p[0]);
      end
      @(negedge clock);
    end
    out_if.a_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (out_if.a_valid !== 1'b1 || out_a !== p[1] || in_if.a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL put_drain2: valid=%b bits=%h ready=%b expected 1 %h 1",
               out_if.a_valid, out_a, in_if.a_ready, p[1]);
    end
    @(negedge clock);
    drive_a(1'b0, '0);
    n_vec++;
    if (out_if.a_valid !== 1'b1 || out_a !== p[2]) begin
      n_err++;
      $display("FAIL put_drain3: valid=%b bits=%h expected 1 %h", out_if.a_valid, out_a, p[2]);
    end
    @(negedge clock);
    n_vec++;
    if (out_if.a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL put_empty: valid=%b expected 0", out_if.a_valid);
    end
  endtask

  task automatic test_d_stream;
    @(negedge clock);
    in_if.d_ready = 1'b1;
    for (int i = 0; i <= 9; i++) begin
      if (i >= 1 && i <= 8) begin
        n_vec++;
        if (in_if.d_valid !== 1'b1 || out_d !== d_beat(i - 1)) begin
          n_err++;
          $display("FAIL d_stream[%0d]: valid=%b bits=%h expected 1 %h", i - 1, in_if.d_valid, out_d, d_beat(i - 1));
        end
      end
      if (i == 9) begin
        n_vec++;
        if (in_if.d_valid !== 1'b0) begin
          n_err++;
          $display("FAIL d_stream_end: valid=%b expected 0", in_if.d_valid);
        end
      end
      if (i < 8) drive_d(1'b1, d_beat(i));
      else       drive_d(1'b0, '0);
      #1;
      if (i < 8 && out_if.d_ready !== 1'b1) begin
        n_vec++;
        n_err++;
        $display("FAIL d_stream_ready[%0d]: d_ready=%b expected 1", i, out_if.d_ready);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_async_reset;
    logic [117:0] b0, b1, b2;
    b0 = a_beat(3'd0, 3'd2, 4'd2, 32'h2000, 8'h0F, 64'hAA);
    b1 = a_beat(3'd0, 3'd2, 4'd3, 32'h2004, 8'hF0, 64'hBB);
    b2 = a_beat(3'd0, 3'd2, 4'd5, 32'h2008, 8'hFF, 64'h55);
    out_if.a_ready = 1'b0;
    drive_a(1'b1, b0);
    @(negedge clock);
    drive_a(1'b1, b1);
    @(negedge clock);
    drive_a(1'b0, '0);
    n_vec++;
    if (out_if.a_valid !== 1'b1 || in_if.a_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_full: valid=%b ready=%b expected 1 0", out_if.a_valid, in_if.a_ready);
    end
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (out_if.a_valid !== 1'b0 || in_if.a_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_async: valid=%b ready=%b expected 0 1", out_if.a_valid, in_if.a_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      n_vec++;
      if (out_if.a_valid !== 1'b0) begin
        n_err++;
        $display("FAIL rst_stays_empty: valid=%b expected 0", out_if.a_valid);
      end
    end
    drive_a(1'b1, b2);
    @(negedge clock);
    drive_a(1'b0, '0);
    n_vec++;
    if (out_if.a_valid !== 1'b1 || out_a !== b2) begin
      n_err++;
      $display("FAIL rst_new_enq: valid=%b bits=%h expected 1 %h", out_if.a_valid, out_a, b2);
    end
    out_if.a_ready = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_independence;
    logic [117:0] b0, b1;
    b0 = a_beat(3'd1, 3'd3, 4'd6, 32'h3000, 8'hFF, 64'h1111);
    b1 = a_beat(3'd1, 3'd3, 4'd7, 32'h3008, 8'hFF, 64'h2222);
    out_if.a_ready = 1'b0;
    in_if.d_ready  = 1'b1;
    drive_a(1'b1, b0);
    @(negedge clock);
    drive_a(1'b1, b1);
    @(negedge clock);
    drive_a(1'b0, '0);
    for (int i = 0; i <= 5; i++) begin
      n_vec++;
      if (in_if.a_ready !== 1'b0 || out_if.a_valid !== 1'b1 || out_a !== b0) begin
        n_err++;
        $display("FAIL indep_a_hold[%0d]: ready=%b valid=%b bits=%h expected 0 1 %h",
                 i, in_if.a_ready, out_if.a_valid, out_a, b0);
      end
      if (i >= 1 && i <= 4) begin
        n_vec++;
        if (in_if.d_valid !== 1'b1 || out_d !== d_beat(i + 19)) begin
          n_err++;
          $display("FAIL indep_d[%0d]: valid=%b bits=%h expected 1 %h", i - 1, in_if.d_valid, out_d, d_beat(i + 19));
        end
      end
      if (i < 4) drive_d(1'b1, d_beat(i + 20));
      else       drive_d(1'b0, '0);
      @(negedge clock);
    end
    n_vec++;
    if (in_if.d_valid !== 1'b0) begin
      n_err++;
      $display("FAIL indep_d_end: valid=%b expected 0", in_if.d_valid);
    end
    out_if.a_ready = 1'b1;
    @(negedge clock);
    n_vec++;
    if (out_if.a_valid !== 1'b1 || out_a !== b1) begin
      n_err++;
      $display("FAIL indep_a_second: valid=%b bits=%h expected 1 %h", out_if.a_valid, out_a, b1);
    end
    @(negedge clock);
    n_vec++;
    if (out_if.a_valid !== 1'b0) begin
      n_err++;
      $display("FAIL indep_a_count: valid=%b expected 0 after two beats", out_if.a_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_backpressure();
    test_d_stream();
    test_async_reset();
    test_independence();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
